// File: rtl/serial_pkg.sv
// Shared definitions for the serial read path.
//   arb_state_t : arbiter state encoding (IDLE, START, ARM, WAIT, RESP, RECOVER)
//   ctr_width   : bit-count width for a buffer of a given size; matches the
//                 read_count port of SerialReadBuffer
//   tmo_width   : width of a counter that must be able to hold timeout_cycles
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARM,
        WAIT,
        RESP,
        RECOVER
    } arb_state_t;

    function automatic int ctr_width(input int buf_size);
        return $clog2(buf_size + 1);
    endfunction

    // A disabled watchdog (0) still gets a 1-bit counter so no port or
    // signal ends up zero-width.
    function automatic int tmo_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector.
//   req        : request vector
//   last       : index of the most recently served requester
//   winner     : one-hot winner (all zero when nothing is requested)
//   winner_idx : index of the winner
//   found      : at least one request is set
// The scan starts at last+1 and wraps, so last itself has lowest priority.
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx,
    output logic          found
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IW'(sum);
    endfunction

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!found && req[wrap_idx(last, off)]) begin
                found      = 1'b1;
                winner_idx = wrap_idx(last, off);
            end
        end
        if (found) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_read_arbiter.sv
// Shares one SerialReadBuffer between NUM_REQ requesters.
//   sys_clk, rst     : clock, asynchronous active-high reset
//   req, req_count   : per-requester request level and packed bit counts
//   grant            : one-hot, held from grant through the response cycle
//   rsp_valid        : one-cycle pulse with rsp_data valid
//   rsp_error        : one-cycle pulse when the watchdog aborts a transfer
//   rsp_data         : last captured word, held until the next good response
//   busy             : arbiter is not idle
//   buf_start, buf_read_count, buf_rst : drive the buffer
//   buf_done, buf_data                 : buffer status and captured word
module serial_read_arbiter
    import serial_pkg::*;
#(
    parameter int BUF_SIZE       = 8,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CTR_SIZE       = ctr_width(BUF_SIZE)
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CTR_SIZE-1:0]  req_count,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUM_REQ-1:0]           rsp_error,
    output logic [BUF_SIZE-1:0]          rsp_data,
    output logic                         busy,
    output logic                         buf_start,
    output logic [CTR_SIZE-1:0]          buf_read_count,
    output logic                         buf_rst,
    input  logic                         buf_done,
    input  logic [BUF_SIZE-1:0]          buf_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t            state_reg, state_next;
    logic [NUM_REQ-1:0]    grant_reg, grant_next;
    logic [IDX_W-1:0]      last_reg, last_next;
    logic                  buf_start_reg, buf_start_next;
    logic                  buf_rst_reg, buf_rst_next;
    logic [CTR_SIZE-1:0]   count_reg, count_next;
    logic [NUM_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
    logic [NUM_REQ-1:0]    rsp_error_reg, rsp_error_next;
    logic [BUF_SIZE-1:0]   rsp_data_reg, rsp_data_next;
    logic [TMO_W-1:0]      tmo_reg, tmo_next;
    logic [TMO_W-1:0]      tmo_inc;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic [CTR_SIZE-1:0]   count_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_count_unpack
            assign count_arr[gi] = req_count[gi*CTR_SIZE +: CTR_SIZE];
        end
    endgenerate

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req        (req),
        .last       (last_reg),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    assign tmo_inc = tmo_reg + TMO_W'(1);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            last_reg      <= LAST_INIT;
            buf_start_reg <= 1'b0;
            buf_rst_reg   <= 1'b0;
            count_reg     <= '0;
            rsp_valid_reg <= '0;
            rsp_error_reg <= '0;
            rsp_data_reg  <= '0;
            tmo_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            last_reg      <= last_next;
            buf_start_reg <= buf_start_next;
            buf_rst_reg   <= buf_rst_next;
            count_reg     <= count_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_error_reg <= rsp_error_next;
            rsp_data_reg  <= rsp_data_next;
            tmo_reg       <= tmo_next;
        end
    end

    // Pulses (start, abort, valid, error) default low so each is one cycle.
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        buf_start_next = 1'b0;
        buf_rst_next   = 1'b0;
        count_next     = count_reg;
        rsp_valid_next = '0;
        rsp_error_next = '0;
        rsp_data_next  = rsp_data_reg;
        tmo_next       = tmo_reg;

        case (state_reg)
            IDLE: begin
                // A buffer still coming out of reset shows done low; wait for it.
                if (buf_done && pick_found) begin
                    grant_next     = pick_onehot;
                    count_next     = count_arr[pick_idx];
                    buf_start_next = 1'b1;
                    last_next      = pick_idx;
                    state_next     = START;
                end
            end
            START: begin
                state_next = ARM;
            end
            ARM: begin
                // done still reflects the previous transfer here.
                state_next = WAIT;
            end
            WAIT: begin
                if (TIMEOUT_CYCLES != 0) begin
                    tmo_next = tmo_inc;
                end
                if (buf_done) begin
                    rsp_data_next  = buf_data;
                    rsp_valid_next = grant_reg;
                    state_next     = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_LIMIT)) begin
                    rsp_error_next = grant_reg;
                    buf_rst_next   = 1'b1;
                    state_next     = RECOVER;
                end
            end
            RESP: begin
                grant_next = '0;
                tmo_next   = '0;
                state_next = IDLE;
            end
            RECOVER: begin
                tmo_next = '0;
                if (buf_done) begin
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign grant          = grant_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_error      = rsp_error_reg;
    assign rsp_data       = rsp_data_reg;
    assign busy           = (state_reg != IDLE);
    assign buf_start      = buf_start_reg;
    assign buf_read_count = count_reg;
    assign buf_rst        = buf_rst_reg;

endmodule

// File: tb/tb_serial_read_arbiter.sv
module tb_serial_read_arbiter;

    localparam int BUF_SIZE       = 8;
    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CTR_SIZE       = 4;

    logic                 sys_clk = 1'b0;
    logic                 rst     = 1'b1;
    logic [1:0]           req       = '0;
    logic [7:0]           req_count = '0;
    logic [1:0]           grant, rsp_valid, rsp_error;
    logic [7:0]           rsp_data;
    logic                 busy, buf_start, buf_rst;
    logic [3:0]           buf_read_count;

    // serial buffer model
    logic                 bm_done;
    logic [7:0]           bm_data;
    logic [1:0]           bm_phase;
    logic [3:0]           bm_left;
    logic [3:0]           bm_idx;
    logic [7:0]           ser_pattern = '0;
    logic                 read_en     = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] req;
        logic [3:0] cnt0;
        logic [3:0] cnt1;
        logic [7:0] bits;
        bit         drop;
        logic [1:0] exp_grant;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] e;
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    vec_t       vecs [8];
    exp_t       sb [$];
    logic [7:0] last_data = '0;

    always #5 sys_clk = ~sys_clk;

    serial_read_arbiter #(
        .BUF_SIZE       (BUF_SIZE),
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CTR_SIZE       (CTR_SIZE)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .req            (req),
        .req_count      (req_count),
        .grant          (grant),
        .rsp_valid      (rsp_valid),
        .rsp_error      (rsp_error),
        .rsp_data       (rsp_data),
        .busy           (busy),
        .buf_start      (buf_start),
        .buf_read_count (buf_read_count),
        .buf_rst        (buf_rst),
        .buf_done       (bm_done),
        .buf_data       (bm_data)
    );

    // Buffer: samples start, one settle cycle, then one bit per read_en
    // cycle (MSB of ser_pattern first), then raises done.
    always @(posedge sys_clk) begin
        if (rst || buf_rst) begin
            bm_done  <= 1'b0;
            bm_phase <= 2'd3;
            bm_left  <= '0;
            bm_idx   <= '0;
            bm_data  <= '0;
        end else if (buf_start) begin
            bm_done  <= 1'b0;
            bm_phase <= 2'd1;
            bm_left  <= buf_read_count;
            bm_idx   <= '0;
            bm_data  <= '0;
        end else begin
            case (bm_phase)
                2'd3: begin
                    bm_done  <= 1'b1;
                    bm_phase <= 2'd0;
                end
                2'd1: bm_phase <= 2'd2;
                2'd2: begin
                    if (bm_left == 4'd0) begin
                        bm_done  <= 1'b1;
                        bm_phase <= 2'd0;
                    end else if (read_en) begin
                        bm_data <= {bm_data[6:0], ser_pattern[3'(7 - bm_idx)]};
                        bm_idx  <= bm_idx + 4'd1;
                        bm_left <= bm_left - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        exp_t x;
        if (rst) return;
        if (|rsp_valid || |rsp_error) begin
            $display("t=%0t rsp valid=%b error=%b grant=%b data=%02h",
                     $time, rsp_valid, rsp_error, grant, rsp_data);
            if (sb.size() == 0) begin
                check("rsp_unexpected", {rsp_valid, rsp_error}, 0);
            end else begin
                x = sb.pop_front();
                check("rsp_valid", rsp_valid, x.v);
                check("rsp_error", rsp_error, x.e);
                check("rsp_grant", grant, x.g);
                check("rsp_data", rsp_data, x.d);
            end
        end
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge sys_clk);
            if (!busy && bm_done) ok = 1'b1;
        end
        check("ready_within_bound", ok, 1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit got;
        int lat;
        wait_ready();
        req         = v.req;
        req_count   = {v.cnt1, v.cnt0};
        ser_pattern = v.bits;
        read_en     = 1'b1;
        sb.push_back('{v: v.exp_grant, e: 2'b00, g: v.exp_grant, d: v.exp_data});
        last_data   = v.exp_data;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check($sformatf("v%0d_grant", idx), grant, v.exp_grant);
        check($sformatf("v%0d_buf_start", idx), buf_start, 1);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (n == 1) check($sformatf("v%0d_buf_start_width", idx), buf_start, 0);
            if (v.drop && n == 3) req = 2'b00;
            if (|rsp_valid || |rsp_error) begin
                got = 1'b1;
                lat = n;
            end
        end
        check($sformatf("v%0d_rsp_seen", idx), got, 1);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        req = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        bit got;
        int lat;

        //            req    cnt0  cnt1  bits   drop  grant  data   lat
        vecs[0] = '{2'b01, 4'd8, 4'd3, 8'hA5, 1'b0, 2'b01, 8'hA5, 12};
        vecs[1] = '{2'b11, 4'd2, 4'd5, 8'hF0, 1'b0, 2'b10, 8'h1E, 9};
        vecs[2] = '{2'b11, 4'd4, 4'd1, 8'h3C, 1'b0, 2'b01, 8'h03, 8};
        vecs[3] = '{2'b11, 4'd0, 4'd0, 8'hFF, 1'b0, 2'b10, 8'h00, 4};
        vecs[4] = '{2'b10, 4'd7, 4'd8, 8'h5A, 1'b0, 2'b10, 8'h5A, 12};
        vecs[5] = '{2'b01, 4'd0, 4'd5, 8'hAA, 1'b0, 2'b01, 8'h00, 4};
        vecs[6] = '{2'b01, 4'd6, 4'd2, 8'hC3, 1'b1, 2'b01, 8'h30, 10};
        vecs[7] = '{2'b11, 4'd1, 4'd3, 8'h80, 1'b0, 2'b10, 8'h04, 7};

        fork
            forever begin
                @(negedge sys_clk);
                monitor_step();
            end
        join_none

        // reset state
        repeat (3) @(negedge sys_clk);
        check("reset_grant", grant, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_error", rsp_error, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_busy", busy, 0);
        check("reset_buf_start", buf_start, 0);
        check("reset_buf_read_count", buf_read_count, 0);
        check("reset_buf_rst", buf_rst, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // watchdog: line goes quiet after three bits
        wait_ready();
        req         = 2'b01;
        req_count   = {4'd8, 4'd8};
        ser_pattern = 8'hFF;
        read_en     = 1'b1;
        sb.push_back('{v: 2'b00, e: 2'b01, g: 2'b01, d: last_data});
        @(posedge sys_clk);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (n == 5) read_en = 1'b0;
            if (|rsp_valid || |rsp_error) begin
                got = 1'b1;
                lat = n;
            end
        end
        check("tmo_seen", got, 1);
        check("tmo_latency", lat, 18);
        check("tmo_buf_rst_high", buf_rst, 1);
        @(negedge sys_clk);
        check("tmo_buf_rst_width", buf_rst, 0);
        check("tmo_error_width", rsp_error, 0);
        req = 2'b00;
        run_vec(8, '{2'b10, 4'd3, 4'd8, 8'h69, 1'b0, 2'b10, 8'h69, 12});

        // asynchronous reset while waiting on requester 0
        wait_ready();
        req         = 2'b01;
        req_count   = {4'd8, 4'd8};
        ser_pattern = 8'h55;
        read_en     = 1'b1;
        @(posedge sys_clk);
        repeat (4) @(negedge sys_clk);
        check("rst_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async_grant", grant, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_rsp_data", rsp_data, 0);
        check("rst_async_outputs", {rsp_valid, rsp_error, buf_start, buf_rst, buf_read_count}, 0);
        req = 2'b00;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        run_vec(9, '{2'b11, 4'd2, 4'd2, 8'hC0, 1'b0, 2'b01, 8'h03, 6});

        repeat (3) @(negedge sys_clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
